// File: rtl/io_dispatch.sv
// rtl/io_dispatch.sv - two-phase (device, port) capture routed into per-device FIFOs
//
// Purpose:
//   Follows the phase of the upstream device/port fetch stage. It captures one
//   (device, port) pair at the edge that ends each phase-1 cycle. It then pushes
//   the port word into the FIFO of that device. Each channel drains through a
//   valid/ready handshake.
//
// Ports:
//   clk          clock
//   rst_n        synchronous active-low reset
//   i_device     device number from the fetch stage
//   i_port       port word from the fetch stage
//   o_dev_data   head word per channel, channel k at [k*W +: W]
//   o_dev_valid  channel k FIFO non-empty
//   i_dev_ready  consumer k accepts the head word
//   o_ovf        sticky per-channel overflow (push into a full FIFO was dropped)
//   o_bad_dev    sticky flag, an illegal device number was captured
//   i_flag_clr   clears o_ovf / o_bad_dev (a same-cycle set event wins)
//   o_drop_cnt   saturating count of dropped pairs (only with IO_DISPATCH_STATS_EN)
//
// Build option: IO_DISPATCH_STATS_EN adds the o_drop_cnt counter.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module io_dispatch #(
  parameter int N_DEV      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [`DATA_WIDTH-1:0]      i_device,
  input  logic [`DATA_WIDTH-1:0]      i_port,
  output logic [N_DEV*`DATA_WIDTH-1:0] o_dev_data,
  output logic [N_DEV-1:0]            o_dev_valid,
  input  logic [N_DEV-1:0]            i_dev_ready,
  output logic [N_DEV-1:0]            o_ovf,
  output logic                        o_bad_dev,
`ifdef IO_DISPATCH_STATS_EN
  output logic [15:0]                 o_drop_cnt,
`endif
  input  logic                        i_flag_clr
);

  localparam int W  = `DATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // One extra bit so the legality compare uses the full device word.
  localparam logic [W:0]    N_DEV_X = (W+1)'(N_DEV);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic             phase;
  logic             capture;
  logic             legal;
  logic             bad_set;
  logic [N_DEV-1:0] ovf_set;

  // Same reset as the fetch stage, so both toggle in lockstep.
  always_ff @(posedge clk) begin
    if (!rst_n) phase <= 1'b0;
    else        phase <= ~phase;
  end

  assign capture = phase;
  assign legal   = ({1'b0, i_device} < N_DEV_X);
  assign bad_set = capture && !legal;

  for (genvar k = 0; k < N_DEV; k++) begin : g_ch
    logic [W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          accept;

    assign push   = capture && legal && (i_device == W'(k));
    assign pop    = (count != '0) && i_dev_ready[k];
    // A full FIFO still accepts when its head leaves in the same cycle.
    assign accept = push && ((count < DEPTH_C) || pop);
    assign ovf_set[k] = push && !accept;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
        if (accept) begin
          mem[wr_ptr] <= i_port;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        case ({accept, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end

    assign o_dev_valid[k]         = (count != '0);
    assign o_dev_data[k*W +: W]   = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_ovf     <= '0;
      o_bad_dev <= 1'b0;
    end else begin
      o_ovf     <= ovf_set | (o_ovf & {N_DEV{~i_flag_clr}});
      o_bad_dev <= bad_set | (o_bad_dev & ~i_flag_clr);
    end
  end

`ifdef IO_DISPATCH_STATS_EN
  logic drop_evt;
  assign drop_evt = bad_set || (ovf_set != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_drop_cnt <= '0;
    end else if (drop_evt) begin
      if (i_flag_clr)                  o_drop_cnt <= 16'd1;
      else if (o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
    end else if (i_flag_clr) begin
      o_drop_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_io_dispatch.sv
// tb/tb_io_dispatch.sv - scoreboard bench for io_dispatch

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_io_dispatch;
  localparam int N_DEV = 4;
  localparam int W     = `DATA_WIDTH;
  localparam logic [W-1:0] IDLE = W'(8'hFF);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [W-1:0]         i_device;
  logic [W-1:0]         i_port;
  logic [N_DEV*W-1:0]   o_dev_data;
  logic [N_DEV-1:0]     o_dev_valid;
  logic [N_DEV-1:0]     i_dev_ready;
  logic [N_DEV-1:0]     o_ovf;
  logic                 o_bad_dev;
  logic                 i_flag_clr;
`ifdef IO_DISPATCH_STATS_EN
  logic [15:0]          o_drop_cnt;
`endif

  io_dispatch #(.N_DEV(N_DEV), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_device   (i_device),
    .i_port     (i_port),
    .o_dev_data (o_dev_data),
    .o_dev_valid(o_dev_valid),
    .i_dev_ready(i_dev_ready),
    .o_ovf      (o_ovf),
    .o_bad_dev  (o_bad_dev),
`ifdef IO_DISPATCH_STATS_EN
    .o_drop_cnt (o_drop_cnt),
`endif
    .i_flag_clr (i_flag_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q [N_DEV][$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted head word is compared with the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < N_DEV; k++) begin
        if (o_dev_valid[k] && i_dev_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            chk($sformatf("unexpected_pop_ch%0d", k), 64'(o_dev_data[k*W +: W]), 64'hDEAD);
          end else begin
            chk($sformatf("data_ch%0d", k), 64'(o_dev_data[k*W +: W]), 64'(exp_q[k].pop_front()));
          end
        end
      end
    end
  end

  // One full (device, port) pair; starts on a phase-0 cycle, ends on one.
  // The scoreboard entry is passed in by the caller when a push is expected.
  task automatic pair(input logic [W-1:0] dev, input logic [W-1:0] port,
                      input bit exp_push, input bit clr0 = 0, input bit clr1 = 0);
    i_device   = dev;
    i_port     = '0;
    i_flag_clr = clr0;
    @(posedge clk); #1;
    i_port     = port;
    i_flag_clr = clr1;
    if (exp_push) exp_q[dev].push_back(port);
    @(posedge clk); #1;
    i_flag_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < N_DEV; k++) exp_q[k].delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    i_device    = IDLE;
    i_port      = '0;
    i_dev_ready = '0;
    i_flag_clr  = 1'b0;
    @(posedge clk); #1;
    do_reset();

    chk("rst_valid", 64'(o_dev_valid), 64'h0);
    chk("rst_ovf",   64'(o_ovf),       64'h0);
    chk("rst_bad",   64'(o_bad_dev),   64'h0);
    chk("rst_data",  64'(o_dev_data),  64'h0);

    // Single word to channel 2.
    pair(W'(8'h02), W'(8'hA5), 1);
    chk("t1_valid", 64'(o_dev_valid), 64'b0100);
    chk("t1_data2", 64'(o_dev_data[2*W +: W]), 64'hA5);
    i_dev_ready = 4'b0100;
    pair(IDLE, '0, 0);
    chk("t1_drained", 64'(o_dev_valid), 64'h0);
    i_dev_ready = '0;

    // Overflow on channel 1: fifth word is dropped.
    pair(W'(8'h01), W'(8'h10), 1, 1);
    pair(W'(8'h01), W'(8'h11), 1);
    pair(W'(8'h01), W'(8'h12), 1);
    pair(W'(8'h01), W'(8'h13), 1);
    pair(W'(8'h01), W'(8'h14), 0);
    chk("t2_valid", 64'(o_dev_valid), 64'b0010);
    chk("t2_ovf",   64'(o_ovf),       64'b0010);
    chk("t2_bad",   64'(o_bad_dev),   64'h0);
    i_dev_ready = 4'b0010;
    i_device = IDLE;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t2_valid_before_last", 64'(o_dev_valid), 64'b0010);
    @(posedge clk); #1;
    chk("t2_valid_after_last", 64'(o_dev_valid), 64'h0);
    chk("t2_ovf_sticky", 64'(o_ovf), 64'b0010);
    i_dev_ready = '0;

    // Full FIFO with a same-cycle pop accepts the new word.
    pair(W'(8'h01), W'(8'h30), 1, 1);
    pair(W'(8'h01), W'(8'h31), 1);
    pair(W'(8'h01), W'(8'h32), 1);
    pair(W'(8'h01), W'(8'h33), 1);
    chk("t3_ovf_clear", 64'(o_ovf), 64'h0);
    i_device = W'(8'h01);
    @(posedge clk); #1;
    i_port = W'(8'h20);
    i_dev_ready = 4'b0010;
    exp_q[1].push_back(W'(8'h20));
    @(posedge clk); #1;
    chk("t3_no_ovf", 64'(o_ovf), 64'h0);
    pair(IDLE, '0, 0);
    pair(IDLE, '0, 0);
    chk("t3_drained", 64'(o_dev_valid), 64'h0);
    chk("t3_ovf_end", 64'(o_ovf), 64'h0);
    i_dev_ready = '0;

    // Illegal device; clear vs set priority.
    pair(W'(8'h07), '0, 0, 1);
    chk("t4_valid", 64'(o_dev_valid), 64'h0);
    chk("t4_bad",   64'(o_bad_dev),   64'h1);
    pair(W'(8'h07), '0, 0, 0, 1);
    chk("t4_set_wins", 64'(o_bad_dev), 64'h1);
    i_device   = W'(8'h00);
    i_flag_clr = 1'b1;
    @(posedge clk); #1;
    i_flag_clr = 1'b0;
    chk("t4_clr_alone", 64'(o_bad_dev), 64'h0);
    i_port = W'(8'hC3);
    exp_q[0].push_back(W'(8'hC3));
    @(posedge clk); #1;

    // Mid-operation reset with channels 0 and 3 occupied.
    pair(W'(8'h03), W'(8'h3C), 1);
    chk("t5_pre_valid", 64'(o_dev_valid), 64'b1001);
    do_reset();
    chk("t5_valid", 64'(o_dev_valid), 64'h0);
    chk("t5_ovf",   64'(o_ovf),       64'h0);
    chk("t5_bad",   64'(o_bad_dev),   64'h0);
    chk("t5_data",  64'(o_dev_data),  64'h0);
    pair(W'(8'h00), W'(8'h5A), 1);
    chk("t5_recap_valid", 64'(o_dev_valid), 64'b0001);
    chk("t5_recap_data",  64'(o_dev_data[0 +: W]), 64'h5A);
    i_dev_ready = 4'b0001;
    pair(IDLE, '0, 0);
    i_dev_ready = '0;

    // Drop accounting: 3 overflows plus 2 illegal devices.
    do_reset();
    pair(W'(8'h01), W'(8'h40), 1);
    pair(W'(8'h01), W'(8'h41), 1);
    pair(W'(8'h01), W'(8'h42), 1);
    pair(W'(8'h01), W'(8'h43), 1);
    pair(W'(8'h01), W'(8'h44), 0);
    pair(W'(8'h01), W'(8'h45), 0);
    pair(W'(8'h01), W'(8'h46), 0);
    pair(W'(8'h09), '0, 0);
    pair(W'(8'h09), '0, 0);
    chk("t6_ovf", 64'(o_ovf),     64'b0010);
    chk("t6_bad", 64'(o_bad_dev), 64'h1);
`ifdef IO_DISPATCH_STATS_EN
    chk("t6_drop_cnt", 64'(o_drop_cnt), 64'd5);
`endif
    i_device   = IDLE;
    i_flag_clr = 1'b1;
    @(posedge clk); #1;
    i_flag_clr = 1'b0;
    chk("t6_ovf_clr", 64'(o_ovf), 64'h0);
`ifdef IO_DISPATCH_STATS_EN
    chk("t6_drop_clr", 64'(o_drop_cnt), 64'd0);
`endif
    @(posedge clk); #1;

    i_dev_ready = '1;
    pair(IDLE, '0, 0);
    pair(IDLE, '0, 0);
    chk("end_valid", 64'(o_dev_valid), 64'h0);
    for (int k = 0; k < N_DEV; k++)
      chk($sformatf("end_q%0d_empty", k), 64'(exp_q[k].size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
